// File: rtl/ram_512.sv
// ram_512: 512 x 16-bit RAM with combinational read, synchronous write and synchronous clear-all reset.
module ram_512 (
    input  logic [15:0] in,
    input  logic        clock,
    input  logic        load,
    input  logic [8:0]  address,
    output logic [15:0] out,
    input  logic        reset
);
    logic [15:0] mem [512];
    // reset wins over load, so a write on a reset edge is dropped
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 512; i++) mem[i] <= '0;
        end else if (load) begin
            mem[address] <= in;
        end
    end
    assign out = mem[address];
endmodule

// File: tb/tb_ram_512.sv
// tb_ram_512: directed scenarios plus randomized traffic checked against an array model of the RAM.
module tb_ram_512;
    logic [15:0] in;
    logic        clock;
    logic        load;
    logic [8:0]  address;
    logic [15:0] out;
    logic        reset;
    int checks;
    int failures;
    logic [15:0] model [512];

    ram_512 dut (
        .in(in),
        .clock(clock),
        .load(load),
        .address(address),
        .out(out),
        .reset(reset)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // one rising edge: the model applies the rules to the inputs held across the edge
    task automatic tick();
        @(posedge clock);
        if (reset) begin
            for (int i = 0; i < 512; i++) model[i] = 16'h0000;
        end else if (load) begin
            model[address] = in;
        end
        #1;
    endtask

    task automatic read_check(input string tag, input logic [8:0] a);
        address = a;
        #1;
        check(tag, out, model[a]);
    endtask

    task automatic write(input logic [8:0] a, input logic [15:0] d);
        address = a;
        in = d;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        in = '0;
        load = 1'b0;
        address = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        // scenario 1: everything cleared
        for (int a = 0; a < 512; a += 16) begin
            address = 9'(a);
            #1;
            check("s1_reset_zero", out, 16'h0000);
        end
        address = 9'd511;
        #1;
        check("s1_reset_511", out, 16'h0000);
        // scenario 2: single write at 128
        write(9'd128, 16'd15);
        for (int a = 0; a < 512; a += 16) begin
            address = 9'(a);
            #1;
            check("s2_sweep", out, (a == 128) ? 16'd15 : 16'd0);
        end
        // scenario 3: top and bottom words are distinct
        write(9'd511, 16'hBEEF);
        write(9'd0, 16'h1234);
        address = 9'd511;
        #1;
        check("s3_addr511", out, 16'hBEEF);
        address = 9'd0;
        #1;
        check("s3_addr0", out, 16'h1234);
        address = 9'd256;
        #1;
        check("s3_addr256", out, 16'h0000);
        // scenario 4: load low holds the stored value
        load = 1'b0;
        in = 16'hFFFF;
        address = 9'd128;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("s4_hold", out, 16'd15);
        end
        // glitches on in/load between edges must not write
        address = 9'd64;
        load = 1'b1;
        in = 16'hAAAA;
        #1;
        load = 1'b0;
        #1;
        tick();
        check("s4_glitch", out, 16'h0000);
        // scenario 5: reset beats a simultaneous write
        reset = 1'b1;
        load = 1'b1;
        in = 16'd7;
        address = 9'd5;
        tick();
        reset = 1'b0;
        load = 1'b0;
        check("s5_addr5", out, 16'h0000);
        address = 9'd128;
        #1;
        check("s5_addr128", out, 16'h0000);
        address = 9'd511;
        #1;
        check("s5_addr511", out, 16'h0000);
        // scenario 6: write-then-read, no bypass before the edge
        address = 9'd200;
        load = 1'b1;
        in = 16'd42;
        #1;
        check("s6_before_edge", out, 16'h0000);
        #2;
        check("s6_stable", out, 16'h0000);
        tick();
        load = 1'b0;
        check("s6_after_edge", out, 16'd42);
        write(9'd201, 16'd9);
        read_check("s6_resume", 9'd201);
        read_check("s6_neighbor", 9'd200);
        // randomized traffic with occasional mid-sequence resets
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 60) == 0);
            load = $urandom_range(0, 1) == 1;
            in = 16'($urandom);
            address = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 7) * 73) : 9'($urandom);
            tick();
            reset = 1'b0;
            load = 1'b0;
            #1;
            check("rnd_same_addr", out, model[address]);
            read_check("rnd_other", 9'($urandom));
        end
        for (int a = 0; a < 512; a++) read_check("final_sweep", 9'(a));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
